// File: rtl/ama_riscv_flow_ctrl.sv
// ama_riscv_flow_ctrl: branch/jump prediction at ID, resolution at EX, PC select, stage flushes and reset clear sequence
//   in : clk, rst (sync, active-high), inst_id, inst_ex, pc_id (BHT read index), pc_ex (BHT update index),
//        bc_a_eq_b, bc_a_lt_b (EX branch compare, signedness already applied)
//   out: pc_sel (0 INC4, 1 ALU, 2 BP target, 3 START_ADDR, 4 EX_INC4), pc_we, bp_taken_id,
//        clear_if/id/ex/mem, mispredict, rst_seq_done
//   AMA_RISCV_BHT_EN: when defined, adds a table of 2-bit saturating counters; otherwise prediction is static not-taken
module ama_riscv_flow_ctrl #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int PC_IDX_LSB  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_id,
    input  logic [31:0]     inst_ex,
    input  logic [XLEN-1:0] pc_id,
    input  logic [XLEN-1:0] pc_ex,
    input  logic            bc_a_eq_b,
    input  logic            bc_a_lt_b,
    output logic [2:0]      pc_sel,
    output logic            pc_we,
    output logic            bp_taken_id,
    output logic            clear_if,
    output logic            clear_id,
    output logic            clear_ex,
    output logic            clear_mem,
    output logic            mispredict,
    output logic            rst_seq_done
);
    logic [2:0] rs;
    logic       branch_ex, jump_ex, pred_ex;
    logic       branch_id, jump_id, pred_raw, taken, settled;
    logic       unused_bits;

    assign branch_id = inst_id[6:0] == 7'b1100011;
    assign jump_id   = inst_id[6:0] == 7'b1100111 || inst_id[6:0] == 7'b1101111;
    assign settled   = rs == 3'b000;
    // funct3 {bit2, bit0}: 00 BEQ, 01 BNE, 10 BLT/BLTU, 11 BGE/BGEU
    assign taken = inst_ex[14] ? (inst_ex[12] ? (bc_a_eq_b | !bc_a_lt_b) : bc_a_lt_b)
                               : (inst_ex[12] ? !bc_a_eq_b : bc_a_eq_b);

    assign mispredict   = !rst && settled && (jump_ex || (branch_ex && taken != pred_ex));
    assign bp_taken_id  = !rst && settled && !mispredict && branch_id && pred_raw;
    assign pc_sel       = rst ? 3'd3 : mispredict ? ((jump_ex || taken) ? 3'd1 : 3'd4) : bp_taken_id ? 3'd2 : 3'd0;
    assign pc_we        = 1'b1;
    assign clear_if     = rst | mispredict;
    assign clear_id     = rst | rs[0] | mispredict;
    assign clear_ex     = rst | rs[1];
    assign clear_mem    = rst | rs[2];
    assign rst_seq_done = settled & !rst;
    assign unused_bits  = ^{inst_id[31:7], inst_ex[31:15], inst_ex[11:0], pc_id, pc_ex};

    // Clear bits drain from the ID end first, so ID/EX/MEM release 1/2/3 cycles after rst
    always_ff @(posedge clk) begin
        rs        <= rst ? 3'b111 : {rs[1:0], 1'b0};
        branch_ex <= !(rst || mispredict) && branch_id;
        jump_ex   <= !(rst || mispredict) && jump_id;
        pred_ex   <= bp_taken_id;
    end

`ifdef AMA_RISCV_BHT_EN
    localparam int IW = $clog2(BHT_ENTRIES);
    logic [1:0]    bht [BHT_ENTRIES];
    logic [IW-1:0] rd_idx, wr_idx;

    assign rd_idx   = pc_id[PC_IDX_LSB +: IW];
    assign wr_idx   = pc_ex[PC_IDX_LSB +: IW];
    assign pred_raw = bht[rd_idx][1];

    // Read above sees the pre-update value when ID and EX hit the same entry
    always_ff @(posedge clk) begin
        if (rst)
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        else if (branch_ex && settled)
            bht[wr_idx] <= taken ? bht[wr_idx] + {1'b0, bht[wr_idx] != 2'b11}
                                 : bht[wr_idx] - {1'b0, bht[wr_idx] != 2'b00};
    end
`else
    localparam int unused_cfg = PC_IDX_LSB + BHT_ENTRIES;
    assign pred_raw = 1'b0;
`endif
endmodule
